// File: rtl/wordle_board_ctrl_if.sv
// wordle_board_ctrl_if: keyboard/target/tick inputs and board-state outputs of the Wordle board sequencer.
interface wordle_board_ctrl_if;
    logic         new_game;
    logic         key_valid;
    logic [1:0]   key_cmd;
    logic [4:0]   key_char;
    logic [24:0]  target;
    logic         tick;
    logic [209:0] display;
    logic         key_ready;
    logic [2:0]   cur_row;
    logic [2:0]   cur_col;
    logic         won;
    logic         lost;

    modport master (
        output new_game, key_valid, key_cmd, key_char, target, tick,
        input  display, key_ready, cur_row, cur_col, won, lost
    );

    modport slave (
        input  new_game, key_valid, key_cmd, key_char, target, tick,
        output display, key_ready, cur_row, cur_col, won, lost
    );
endinterface

// File: rtl/wordle_board_ctrl.sv
// wordle_board_ctrl: Wordle board sequencer; letter entry, duplicate-aware scoring, colour reveal, win/loss.
// Define REVEAL_ANIM_EN to reveal one column per tick; otherwise all five colours land in one cycle.
module wordle_board_ctrl #(
    parameter int NUM_ROWS = 6
) (
    input logic                dclk,
    input logic                clr,
    wordle_board_ctrl_if.slave bus
);
    typedef enum logic [2:0] {ENTRY, EVAL_G, EVAL_Y, REVEAL, WON, LOST} state_t;

    state_t     r_state, w_next;
    logic [6:0] r_tile [30];
    logic [1:0] r_res [5];
    logic [2:0] r_row, r_col, r_j, r_c;
    logic [4:0] r_green, r_used;
    logic [4:0] w_base, w_gch, w_green;
    logic [2:0] w_k;
    logic       w_found, w_fire, w_last;

    assign w_base = 5'(r_row) * 5'd5;
    assign w_gch  = r_tile[w_base + 5'(r_j)][4:0];
    assign w_last = r_row == 3'(NUM_ROWS - 1);
`ifdef REVEAL_ANIM_EN
    assign w_fire = bus.tick && r_c == 3'd4;
`else
    logic w_unused_tick;
    assign w_unused_tick = bus.tick;
    assign w_fire = 1'b1;
`endif

    // Descending scan so the lowest free matching target position wins.
    always_comb begin
        w_found = 1'b0;
        w_k     = 3'd0;
        w_green = '0;
        for (int k = 4; k >= 0; k--)
            if (bus.target[5*k +: 5] == w_gch && !r_green[k] && !r_used[k]) begin
                w_found = 1'b1;
                w_k     = 3'(k);
            end
        for (int k = 0; k < 5; k++)
            w_green[k] = r_tile[w_base + 5'(k)][4:0] == bus.target[5*k +: 5];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ENTRY:   if (bus.key_valid && bus.key_cmd == 2'd2 && r_col == 3'd5) w_next = EVAL_G;
            EVAL_G:  w_next = EVAL_Y;
            EVAL_Y:  if (r_j == 3'd4) w_next = REVEAL;
            REVEAL:  if (w_fire) w_next = &r_green ? WON : w_last ? LOST : ENTRY;
            default: ;
        endcase
    end

    always_ff @(posedge dclk or posedge clr)
        if (clr) r_state <= ENTRY;
        else     r_state <= bus.new_game ? ENTRY : w_next;

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 30; i++) r_tile[i] <= 7'd0;
            for (int i = 0; i < 5; i++) r_res[i] <= 2'd0;
            {r_row, r_col, r_j, r_c, r_green, r_used} <= '0;
        end else if (bus.new_game) begin
            for (int i = 0; i < 30; i++) r_tile[i] <= 7'd0;
            for (int i = 0; i < 5; i++) r_res[i] <= 2'd0;
            {r_row, r_col, r_j, r_c, r_green, r_used} <= '0;
        end else begin
            case (r_state)
                ENTRY: if (bus.key_valid) begin
                    if (bus.key_cmd == 2'd0 && bus.key_char >= 5'd1 && bus.key_char <= 5'd26 && r_col < 3'd5) begin
                        r_tile[w_base + 5'(r_col)] <= {2'b00, bus.key_char};
                        r_col <= r_col + 3'd1;
                    end else if (bus.key_cmd == 2'd1 && r_col != 3'd0) begin
                        r_tile[w_base + 5'(r_col) - 5'd1] <= 7'd0;
                        r_col <= r_col - 3'd1;
                    end
                end
                EVAL_G: begin
                    r_green <= w_green;
                    r_used  <= '0;
                    r_j     <= 3'd0;
                end
                EVAL_Y: begin
                    r_res[r_j] <= r_green[r_j] ? 2'd1 : w_found ? 2'd2 : 2'd3;
                    if (!r_green[r_j] && w_found) r_used[w_k] <= 1'b1;
                    r_j <= (r_j == 3'd4) ? 3'd0 : r_j + 3'd1;
                    r_c <= 3'd0;
                end
                REVEAL: begin
`ifdef REVEAL_ANIM_EN
                    if (bus.tick) begin
                        r_tile[w_base + 5'(r_c)][6:5] <= r_res[r_c];
                        r_c <= r_c + 3'd1;
                    end
`else
                    for (int k = 0; k < 5; k++) r_tile[w_base + 5'(k)][6:5] <= r_res[k];
`endif
                    if (w_fire && !(&r_green) && !w_last) begin
                        r_row <= r_row + 3'd1;
                        r_col <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.display = '0;
        for (int i = 0; i < 30; i++) bus.display[7*i +: 7] = r_tile[i];
    end

    assign bus.key_ready = r_state == ENTRY;
    assign bus.cur_row   = r_row;
    assign bus.cur_col   = r_col;
    assign bus.won       = r_state == WON;
    assign bus.lost      = r_state == LOST;
endmodule

// File: tb/tb_wordle_board_ctrl.sv
// tb_wordle_board_ctrl: directed and randomized games checked against a letter-count Wordle model.
module tb_wordle_board_ctrl;
    localparam int NR = 6;

    logic dclk = 1'b0;
    logic clr  = 1'b1;

    wordle_board_ctrl_if bus();
    wordle_board_ctrl #(.NUM_ROWS(NR)) dut (.dclk(dclk), .clr(clr), .bus(bus.slave));

    always #5 dclk = ~dclk;

    int         n_chk = 0;
    int         n_err = 0;
    int         g_abort = -1;
    logic [4:0] m_char [30];
    logic [1:0] m_color [30];
    logic [4:0] m_tgt [5];
    logic [1:0] m_res [5];
    int         m_row, m_col;
    bit         m_busy, m_won, m_lost;

    task automatic cyc();
        @(posedge dclk);
        #1;
    endtask

    task automatic check(string tag, logic [209:0] got, logic [209:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [209:0] m_disp();
        logic [209:0] d = '0;
        for (int i = 0; i < 30; i++) d[7*i +: 7] = {m_color[i], m_char[i]};
        return d;
    endfunction

    task automatic check_all(string tag);
        check({tag, ".display"}, bus.display, m_disp());
        check({tag, ".cur_row"}, 210'(bus.cur_row), 210'(m_row));
        check({tag, ".cur_col"}, 210'(bus.cur_col), 210'(m_col));
        check({tag, ".key_ready"}, 210'(bus.key_ready), 210'(!m_busy && !m_won && !m_lost));
        check({tag, ".won"}, 210'(bus.won), 210'(m_won));
        check({tag, ".lost"}, 210'(bus.lost), 210'(m_lost));
    endtask

    task automatic model_clear();
        for (int i = 0; i < 30; i++) begin
            m_char[i]  = 5'd0;
            m_color[i] = 2'd0;
        end
        m_row = 0; m_col = 0;
        m_busy = 0; m_won = 0; m_lost = 0;
    endtask

    task automatic ng();
        bus.new_game = 1'b1;
        cyc();
        bus.new_game = 1'b0;
        model_clear();
        check_all("new_game");
    endtask

    task automatic post_ng();
        repeat (3) begin
            bus.tick = 1'b1;
            cyc();
            bus.tick = 1'b0;
            check_all("post_ng_tick");
        end
    endtask

    task automatic set_target(logic [24:0] w);
        bus.target = w;
        for (int k = 0; k < 5; k++) m_tgt[k] = w[5*k +: 5];
    endtask

    function automatic logic [24:0] mk(int a, int b, int c, int d, int e);
        return {5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    function automatic logic [24:0] rand_word(int hi);
        logic [24:0] w;
        for (int k = 0; k < 5; k++) w[5*k +: 5] = 5'($urandom_range(1, hi));
        return w;
    endfunction

    // Standard Wordle scoring: greens first, then yellows limited by remaining letter counts.
    task automatic score();
        int         cnt [32];
        logic [4:0] g;
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        for (int k = 0; k < 5; k++)
            if (m_char[m_row*5 + k] != m_tgt[k]) cnt[m_tgt[k]]++;
        for (int j = 0; j < 5; j++) begin
            g = m_char[m_row*5 + j];
            if (g == m_tgt[j]) m_res[j] = 2'd1;
            else if (cnt[g] > 0) begin
                m_res[j] = 2'd2;
                cnt[g]--;
            end else m_res[j] = 2'd3;
        end
    endtask

    task automatic decide();
        bit all_g = 1;
        for (int j = 0; j < 5; j++) if (m_res[j] != 2'd1) all_g = 0;
        if (all_g) m_won = 1;
        else if (m_row == NR - 1) m_lost = 1;
        else begin
            m_row++;
            m_col = 0;
        end
        m_busy = 0;
    endtask

    task automatic reveal();
        score();
        for (int i = 0; i < 6; i++) begin
`ifndef REVEAL_ANIM_EN
            if (g_abort == i) begin
                ng();
                post_ng();
                return;
            end
`else
            bus.tick = 1'($urandom_range(0, 1));
`endif
            cyc();
            bus.tick = 1'b0;
            check_all("eval");
        end
`ifdef REVEAL_ANIM_EN
        for (int c = 0; c < 5; c++) begin
            repeat ($urandom_range(0, 2)) begin
                cyc();
                check_all("gap");
            end
            if (g_abort == c) begin
                ng();
                post_ng();
                return;
            end
            bus.tick = 1'b1;
            cyc();
            bus.tick = 1'b0;
            m_color[m_row*5 + c] = m_res[c];
            if (c == 4) decide();
            check_all("tick");
        end
`else
        cyc();
        for (int c = 0; c < 5; c++) m_color[m_row*5 + c] = m_res[c];
        decide();
        check_all("reveal");
`endif
    endtask

    task automatic press(int cmd, int ch);
        bus.key_valid = 1'b1;
        bus.key_cmd   = 2'(cmd);
        bus.key_char  = 5'(ch);
        cyc();
        bus.key_valid = 1'b0;
        if (!m_busy && !m_won && !m_lost) begin
            if (cmd == 0 && ch >= 1 && ch <= 26 && m_col < 5) begin
                m_char[m_row*5 + m_col] = 5'(ch);
                m_col++;
            end else if (cmd == 1 && m_col > 0) begin
                m_col--;
                m_char[m_row*5 + m_col] = 5'd0;
            end else if (cmd == 2 && m_col == 5) m_busy = 1;
        end
        check_all("key");
        if (m_busy) reveal();
    endtask

    task automatic type_word(logic [24:0] w, bit noise);
        for (int k = 0; k < 5; k++) begin
            if (noise && $urandom_range(0, 3) == 0) begin
                press(0, $urandom_range(1, 26));
                press(1, 0);
            end
            if (noise && $urandom_range(0, 4) == 0) press(3, $urandom_range(0, 31));
            if (noise && $urandom_range(0, 4) == 0) press(0, $urandom_range(27, 31));
            press(0, int'(w[5*k +: 5]));
        end
        press(2, 0);
    endtask

    initial begin
        logic [24:0] tgt, gs;
        logic [9:0]  cols;
        bus.new_game = 1'b0; bus.key_valid = 1'b0; bus.key_cmd = 2'd0;
        bus.key_char = 5'd0; bus.tick = 1'b0; bus.target = '0;
        model_clear();
        repeat (3) @(posedge dclk);
        #1;
        check_all("reset_held");
        clr = 1'b0;
        cyc();
        check_all("reset");

        // CRANE with boundary keys, then a correct guess
        set_target(mk(3, 18, 1, 14, 5));
        press(1, 0);
        press(0, 3); press(0, 18); press(0, 1);
        press(2, 0);
        press(0, 27);
        press(0, 0);
        press(3, 5);
        press(0, 14); press(0, 5);
        press(0, 7);
        press(2, 0);
        check("crane_won", 210'(bus.won), 210'(1));
        press(0, 4);
        ng();

        // EERIE against CRANE: duplicate E handling
        press(0, 5); press(0, 5); press(0, 18); press(0, 9); press(0, 5);
        press(2, 0);
        for (int c = 0; c < 5; c++) cols[2*c +: 2] = bus.display[7*c + 5 +: 2];
        check("eerie_colours", 210'(cols), 210'({2'd1, 2'd3, 2'd2, 2'd3, 2'd3}));
        check("eerie_row", 210'(bus.cur_row), 210'(1));
        ng();

        // six wrong guesses end in a loss
        tgt = rand_word(26);
        set_target(tgt);
        for (int r = 0; r < NR; r++) begin
            do gs = rand_word(26); while (gs == tgt);
            type_word(gs, 1);
        end
        check("lost_flag", 210'(bus.lost), 210'(1));
        press(0, 3);
        ng();

        // random games with a small alphabet to stress duplicate letters
        for (int gm = 0; gm < 8; gm++) begin
            tgt = rand_word(3);
            set_target(tgt);
            while (!m_won && !m_lost) type_word(($urandom_range(0, 3) == 0) ? tgt : rand_word(3), 1);
            ng();
        end

        // new_game in the middle of scoring/reveal
        set_target(mk(3, 18, 1, 14, 5));
        g_abort = 2;
        type_word(mk(5, 5, 18, 9, 5), 0);
        g_abort = -1;

        // asynchronous clr between edges
        press(0, 8); press(0, 9);
        #2 clr = 1'b1;
        #1;
        model_clear();
        check_all("async_clr");
        cyc();
        clr = 1'b0;
        cyc();
        check_all("after_clr");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/wordle_board_ctrl.md
Name: wordle_board_ctrl

Overview:
- Game-board sequencer that owns the 210-bit tile vector consumed by the VGA renderer.
- Accepts keyboard commands: letter, backspace, enter.
- Places letters in the active row, scores a submitted guess against the target word with correct duplicate handling, and reveals tile colours one column per pacing tick.
- Tracks win/loss.

Parameters:
- NUM_ROWS, 6, number of guess rows (1..6); tiles of rows >= NUM_ROWS stay zero.

Ports:
- dclk  in  1  clock (25 MHz pixel clock domain)
- clr  in  1  reset, asynchronous, active-high
- new_game  in  1  synchronous clear pulse, highest priority
- key_valid  in  1  one-cycle key strobe
- key_cmd  in  2  0=letter, 1=backspace, 2=enter, 3=ignored
- key_char  in  5  letter code 1..26 (A..Z); used when key_cmd=0
- target  in  25  target word; letter k at [5k+4:5k], k=0 is leftmost
- tick  in  1  reveal pacing strobe (single-cycle pulse)
- display  out  210  tile vector; tile i=row*5+col, char at [7i+4:7i], colour at [7i+6:7i+5]
- key_ready  out  1  high only in ENTRY
- cur_row  out  3  active row 0..NUM_ROWS-1
- cur_col  out  3  next entry column 0..5
- won  out  1  sticky until clr/new_game
- lost  out  1  sticky until clr/new_game

Behaviour:
- Colour codes: 0=blank/unscored, 1=green, 2=yellow, 3=gray.
- Reset (clr) and new_game values:
  - display=0, cur_row=0, cur_col=0, won=0, lost=0.
  - Internal green/yellow/used masks = 0; state=ENTRY.
  - new_game acts on the next dclk edge in any state, including mid-EVAL or mid-REVEAL.
- States: ENTRY, EVAL_G, EVAL_Y, REVEAL, WON, LOST.
- ENTRY: acts on key_valid only; keys in any other state are dropped, with no queueing.
  - Letter with key_char in 1..26 and cur_col<5: write the char to tile (cur_row,cur_col) with colour 0, then cur_col+1. key_char 0 or >26, or cur_col=5: ignored.
  - Backspace with cur_col>0: cur_col-1, and that tile's char is cleared to 0. At cur_col=0: ignored.
  - Enter with cur_col=5: go to EVAL_G. Otherwise ignored.
- EVAL_G (1 cycle):
  - green[k] = guess[k]==target[k] for k=0..4.
  - used cleared; scan column j=0; go to EVAL_Y.
- EVAL_Y (1 cycle per column, 5 cycles total):
  - If green[j]: result[j]=1.
  - Else find the lowest k with target[k]==guess[j], !green[k], !used[k]. If found: result[j]=2, used[k]=1. Otherwise result[j]=3.
  - After j=4, go to REVEAL with reveal column 0.
- REVEAL:
  - On each tick, write result[c] into the colour field of tile (cur_row,c), then c+1. Ticks in other states are ignored.
  - On the tick that writes c=4, on the same edge:
    - all green -> WON, won=1.
    - else if cur_row=NUM_ROWS-1 -> LOST, lost=1.
    - else cur_row+1, cur_col=0, ENTRY.
- WON/LOST: terminal. key_ready=0; display frozen until clr/new_game.
- Priority within a cycle: clr > new_game > key/tick handling. Only one key command exists per cycle by encoding.
- Minimum latency from enter to first colour write: 6 cycles plus the first tick.
- display is registered; a tile char/colour is visible the cycle after the accepting edge.

Optional Feature:
- Macro REVEAL_ANIM_EN.
- Defined: REVEAL paced by tick as above.
- Undefined: tick is ignored; REVEAL writes all five colours and performs the win/loss/next-row decision in a single cycle, entered directly after EVAL_Y.

Test Plan:
- Target CRANE (3,18,1,14,5). Type C,R,A,N,E + enter, then 5 ticks -> row 0 colours 1,1,1,1,1; won=1; key_ready=0; display colour bits of row 1 still 0.
- Target CRANE, guess EERIE (5,5,18,9,5) -> colours 3,3,2,3,1; cur_row=1, cur_col=0, key_ready=1 after the 5th tick.
- Boundaries:
  - enter at cur_col=3 -> ignored, state stays ENTRY.
  - 6th letter -> ignored, cur_col stays 5.
  - backspace at cur_col=0 -> no change.
  - key_char=27 -> ignored.
- Six wrong guesses (NUM_ROWS=6) -> lost=1 after the last reveal; subsequent letters ignored; new_game -> display=0, cur_row=0, lost=0.
- Pulse new_game after the 2nd reveal tick -> next cycle: display=0, state ENTRY; further ticks produce no writes.
- With REVEAL_ANIM_EN undefined: CRANE/EERIE -> all five colours appear together 7 cycles after enter, with tick held at 0.
